video_pattern_gen: RTL and testbench



---
 rtl/video_pkg.sv | 53 +++++
 rtl/video_timing_gen.sv | 86 ++++++++
 rtl/video_pattern_gen.sv | 209 ++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video pattern source and its raster timing generator.
// Contents: FSM/mode encodings, blanking and white levels, colour-bar table,
// raster total helper and the grey-ramp level function.
package video_pkg;

    typedef enum logic {StIdle, StRun} timing_state_e;

    typedef enum logic [1:0] {
        ModeBars    = 2'd0,
        ModeGrey    = 2'd1,
        ModeChecker = 2'd2,
        ModeScroll  = 2'd3
    } pattern_mode_e;

    // 8-bit YCbCr triple; wider components are derived by left-shifting.
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycc_t;

    localparam logic [7:0] BLK_Y = 8'h10;
    localparam logic [7:0] BLK_C = 8'h80;
    localparam logic [7:0] WHT_Y = 8'hEB;

    function automatic int line_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic ycc_t colour_bar(logic [2:0] idx);
        ycc_t c;
        case (idx)
            3'd0:    c = {8'hEB, 8'h80, 8'h80}; // white
            3'd1:    c = {8'hDD, 8'h0F, 8'h8B}; // yellow
            3'd2:    c = {8'hBC, 8'h9A, 8'h0F}; // cyan
            3'd3:    c = {8'h40, 8'h66, 8'hF1}; // red
            3'd4:    c = {8'hAD, 8'h29, 8'h1A}; // green
            3'd5:    c = {8'h1F, 8'hF1, 8'h75}; // blue
            3'd6:    c = {8'h10, 8'h80, 8'h80}; // black
            default: c = {8'h4F, 8'hD7, 8'hE6}; // magenta
        endcase
        return c;
    endfunction

    // Only ever called with constant arguments, so the division folds away.
    function automatic logic [7:0] grey_level(int k, int steps);
        if (k >= steps - 1) begin
            return 8'd16;
        end
        return 8'(235 - (219 * k) / (steps - 1));
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: IDLE/RUN control plus horizontal/vertical counters.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   enable        starts the raster at h=v=0; dropping it returns to IDLE next edge
//   h, v          registered pixel/line counters (held at 0 in IDLE)
//   run           registered RUN state
//   active/hsync/vsync   decoded from the counters, active-high, same cycle as h/v
//   first, last   first and last active pixel of the frame
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOTAL + 1),
    localparam int VW      = $clog2(V_TOTAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          run,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          first,
    output logic          last
);

    localparam logic [HW-1:0] H_END    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LASTA  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_END    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LASTA  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    timing_state_e state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            h     <= '0;
            v     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    h <= '0;
                    v <= '0;
                    if (enable) state <= StRun;
                end
                default: begin
                    if (!enable) begin
                        state <= StIdle;
                        h     <= '0;
                        v     <= '0;
                    end else if (h == H_END) begin
                        h <= '0;
                        v <= (v == V_END) ? '0 : v + 1'b1;
                    end else begin
                        h <= h + 1'b1;
                    end
                end
            endcase
        end
    end

    assign run    = (state == StRun);
    assign active = run && (h < H_ACT) && (v < V_ACT);
    assign hsync  = run && (h >= HS_BEG) && (h < HS_END);
    assign vsync  = run && (v >= VS_BEG) && (v < VS_END);
    assign first  = run && (h == '0) && (v == '0);
    assign last   = run && (h == H_LASTA) && (v == V_LASTA);

endmodule

// File: rtl/video_pattern_gen.sv
// HDMI test-pattern source, YCbCr 4:2:2 on a {chroma, luma} bus.
// Pipeline: stage0 counters (video_timing_gen) -> stage1 colour lookup -> stage2 pins.
// Ports:
//   i_clk, i_rst        pixel clock, synchronous active-high reset
//   i_config_ok         transmitter ready; runs the raster while high
//   i_mode              0 bars, 1 grey ramp, 2 checker, 3 scrolling bar (per frame)
//   o_hdmi_clk          pixel clock forwarded to the transmitter
//   o_hdmi_hsync/vsync  syncs, polarity set by SYNC_ACTIVE_LOW
//   o_hdmi_de           active video
//   o_hdmi_data         {chroma, luma}, 2*CW bits
//   o_frame_start       pulse with the first active pixel of a frame
//   o_frame_cnt         completed frames, cleared whenever the raster stops
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int NUM_BARS        = 8,
    parameter int CW              = 8,
    parameter int CHECK_LOG2      = 5,
    parameter int SCROLL_W        = 64,
    parameter int SCROLL_STEP     = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_config_ok,
    input  logic [1:0]      i_mode,
    output logic            o_hdmi_clk,
    output logic            o_hdmi_hsync,
    output logic            o_hdmi_vsync,
    output logic            o_hdmi_de,
    output logic [2*CW-1:0] o_hdmi_data,
    output logic            o_frame_start,
    output logic [7:0]      o_frame_cnt
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int BAR_W   = H_ACTIVE / NUM_BARS;

    localparam logic [HW-1:0] H_END    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
    localparam logic [HW:0]   HA_X     = (HW + 1)'(H_ACTIVE);
    localparam logic [HW:0]   STEP_X   = (HW + 1)'(SCROLL_STEP);
    localparam logic [HW:0]   SW_X     = (HW + 1)'(SCROLL_W);
    localparam logic          SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    function automatic logic [CW-1:0] scale(logic [7:0] c);
        return CW'(c) << (CW - 8);
    endfunction

    localparam logic [2*CW-1:0] BLANK = {scale(BLK_C), scale(BLK_Y)};

    assign o_hdmi_clk = i_clk;

    // Stage 0: raster counters
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          run, active, hsync, vsync, first, last;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (i_clk),
        .rst    (i_rst),
        .enable (i_config_ok),
        .h      (h),
        .v      (v),
        .run    (run),
        .active (active),
        .hsync  (hsync),
        .vsync  (vsync),
        .first  (first),
        .last   (last)
    );

    // Bar index tracks h without a divider; it is valid in the same cycle as h.
    logic [HW-1:0] bar_px;
    logic [4:0]    bar_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst || !run || h == H_END) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h < H_ACT) begin
            if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    // Mode is taken live on the first pixel so that pixel already uses it.
    pattern_mode_e frame_mode, mode;
    assign mode = first ? pattern_mode_e'(i_mode) : frame_mode;

    always_ff @(posedge i_clk) begin
        if (i_rst) frame_mode <= ModeBars;
        else       frame_mode <= mode;
    end

    // Scroll position advances on the last active pixel, ready for the next frame.
    logic [HW-1:0] pos, pos_next;
    logic [HW:0]   pos_sum, diff;
    logic          in_bar;

    always_comb begin
        pos_sum = {1'b0, pos} + STEP_X;
        if (pos_sum >= HA_X) pos_sum = pos_sum - HA_X;
        pos_next = pos_sum[HW-1:0];
        diff = (h >= pos) ? {1'b0, h} - {1'b0, pos} : {1'b0, h} + HA_X - {1'b0, pos};
        in_bar = (diff < SW_X);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !run) pos <= '0;
        else if (last)     pos <= pos_next;
    end

    logic [7:0] grey_lut [16];
    for (genvar k = 0; k < 16; k++) begin : g_grey
        localparam logic [7:0] LEVEL = grey_level(k, NUM_BARS);
        assign grey_lut[k] = LEVEL;
    end

    ycc_t pix;
    always_comb begin
        pix = {BLK_Y, BLK_C, BLK_C};
        unique case (mode)
            ModeBars:    pix   = colour_bar(bar_idx[2:0]);
            ModeGrey:    pix.y = grey_lut[bar_idx[3:0]];
            ModeChecker: pix.y = (h[CHECK_LOG2] ^ v[CHECK_LOG2]) ? WHT_Y : BLK_Y;
            ModeScroll:  pix.y = in_bar ? WHT_Y : BLK_Y;
        endcase
    end

    // Stage 1: colour and 4:2:2 packing; odd pixels reuse the even pixel's Cr.
    logic            de1, hs1, vs1, fs1, last1, run1;
    logic [2*CW-1:0] data1;
    logic [CW-1:0]   cr_hold;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            de1     <= 1'b0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            fs1     <= 1'b0;
            last1   <= 1'b0;
            run1    <= 1'b0;
            data1   <= BLANK;
            cr_hold <= '0;
        end else begin
            de1   <= active;
            hs1   <= hsync;
            vs1   <= vsync;
            fs1   <= first;
            last1 <= last;
            run1  <= run;
            if (!active) begin
                data1 <= BLANK;
            end else if (h[0]) begin
                data1 <= {cr_hold, scale(pix.y)};
            end else begin
                data1   <= {scale(pix.cb), scale(pix.y)};
                cr_hold <= scale(pix.cr);
            end
        end
    end

    // Stage 2: output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hdmi_hsync  <= SYNC_IDLE;
            o_hdmi_vsync  <= SYNC_IDLE;
            o_hdmi_de     <= 1'b0;
            o_hdmi_data   <= BLANK;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= 8'd0;
        end else begin
            o_hdmi_hsync  <= hs1 ^ SYNC_IDLE;
            o_hdmi_vsync  <= vs1 ^ SYNC_IDLE;
            o_hdmi_de     <= de1;
            o_hdmi_data   <= data1;
            o_frame_start <= fs1;
            if (!run1)      o_frame_cnt <= 8'd0;
            else if (last1) o_frame_cnt <= o_frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a small raster:
// 16+2+3+3 = 24 clocks/line, 6+1+2+1 = 10 lines/frame, 240 clocks/frame, 2-px bars.
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        config_ok;
    logic [1:0]  mode;
    logic        hdmi_clk;
    logic        hsync, vsync, de, fs;
    logic [15:0] data;
    logic [7:0]  fcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE        (16),
        .H_FP            (2),
        .H_SYNC          (3),
        .H_BP            (3),
        .V_ACTIVE        (6),
        .V_FP            (1),
        .V_SYNC          (2),
        .V_BP            (1),
        .SYNC_ACTIVE_LOW (1),
        .NUM_BARS        (8),
        .CW              (8),
        .CHECK_LOG2      (2),
        .SCROLL_W        (6),
        .SCROLL_STEP     (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_config_ok   (config_ok),
        .i_mode        (mode),
        .o_hdmi_clk    (hdmi_clk),
        .o_hdmi_hsync  (hsync),
        .o_hdmi_vsync  (vsync),
        .o_hdmi_de     (de),
        .o_hdmi_data   (data),
        .o_frame_start (fs),
        .o_frame_cnt   (fcnt)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench at the sample point of the next frame_start pulse.
    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (fs === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        config_ok = 1'b0;
        mode = 2'd0;
        step(3);
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de got=%b want=0", de); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got=%b want=1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got=%b want=1", vsync); end
        checks++; if (data !== 16'h8010) begin errors++; $display("FAIL reset_data got=%h want=8010", data); end
        checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b want=0", fs); end
        checks++; if (fcnt !== 8'd0) begin errors++; $display("FAIL reset_fcnt got=%0d want=0", fcnt); end
        rst = 1'b0;
        step(3);
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL idle_de got=%b want=0", de); end
    endtask

    task automatic test_startup_timing();
        int hh, vv, bad_de, bad_hs, bad_vs, bad_fs, de_cnt;
        logic e_de, e_hs, e_vs, e_fs;
        bad_de = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0; de_cnt = 0;
        config_ok = 1'b1;
        step(1);
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL start_de_c0 got=%b want=0", de); end
        step(1);
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL start_de_c1 got=%b want=0", de); end
        step(1);
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL start_de_c2 got=%b want=1", de); end
        checks++; if (fs !== 1'b1) begin errors++; $display("FAIL start_fs got=%b want=1", fs); end
        for (int k = 0; k < 240; k++) begin
            hh = k % 24;
            vv = k / 24;
            e_de = (hh < 16) && (vv < 6);
            e_hs = !((hh >= 18) && (hh < 21));
            e_vs = !((vv >= 7) && (vv < 9));
            e_fs = (k == 0);
            if (de !== e_de) bad_de++;
            if (hsync !== e_hs) bad_hs++;
            if (vsync !== e_vs) bad_vs++;
            if (fs !== e_fs) bad_fs++;
            if (de === 1'b1) de_cnt++;
            if (k == 134) begin
                checks++; if (fcnt !== 8'd0) begin errors++; $display("FAIL fcnt_before_last got=%0d want=0", fcnt); end
            end
            if (k == 135) begin
                checks++; if (fcnt !== 8'd1) begin errors++; $display("FAIL fcnt_at_last got=%0d want=1", fcnt); end
            end
            step(1);
        end
        checks++; if (bad_de !== 0) begin errors++; $display("FAIL raster_de bad_cycles=%0d want=0", bad_de); end
        checks++; if (bad_hs !== 0) begin errors++; $display("FAIL raster_hsync bad_cycles=%0d want=0", bad_hs); end
        checks++; if (bad_vs !== 0) begin errors++; $display("FAIL raster_vsync bad_cycles=%0d want=0", bad_vs); end
        checks++; if (bad_fs !== 0) begin errors++; $display("FAIL raster_fs bad_cycles=%0d want=0", bad_fs); end
        checks++; if (de_cnt !== 96) begin errors++; $display("FAIL de_count got=%0d want=96", de_cnt); end
        checks++; if (fs !== 1'b1) begin errors++; $display("FAIL frame_period fs got=%b want=1", fs); end
        checks++; if (fcnt !== 8'd1) begin errors++; $display("FAIL fcnt_frame1 got=%0d want=1", fcnt); end
    endtask

    task automatic test_bars();
        logic [15:0] exp_px [16];
        bit ok;
        exp_px = '{16'h80EB, 16'h80EB, 16'h0FDD, 16'h8BDD, 16'h9ABC, 16'h0FBC, 16'h6640, 16'hF140,
                   16'h29AD, 16'h1AAD, 16'hF11F, 16'h751F, 16'h8010, 16'h8010, 16'hD74F, 16'hE64F};
        wait_fs(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bars_fs_timeout got=%b want=1", ok); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (data !== exp_px[i] || de !== 1'b1) begin
                errors++;
                $display("FAIL bars_px%0d got=%h de=%b want=%h de=1", i, data, de, exp_px[i]);
            end
            step(1);
        end
        checks++; if (data !== 16'h8010) begin errors++; $display("FAIL bars_blank got=%h want=8010", data); end
        step(8);
        checks++; if (data !== 16'h80EB) begin errors++; $display("FAIL bars_line1_px0 got=%h want=80eb", data); end
    endtask

    task automatic test_mode_change();
        logic [7:0] grey [8];
        bit ok;
        grey = '{8'hEB, 8'hCC, 8'hAD, 8'h8E, 8'h6E, 8'h4F, 8'h30, 8'h10};
        wait_fs(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL chg_fs_timeout got=%b want=1", ok); end
        mode = 2'd1;
        step(2);
        checks++; if (data !== 16'h0FDD) begin errors++; $display("FAIL chg_hold_px2 got=%h want=0fdd", data); end
        step(36);
        checks++; if (data !== 16'hD74F) begin errors++; $display("FAIL chg_hold_l1px14 got=%h want=d74f", data); end
        wait_fs(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL grey_fs_timeout got=%b want=1", ok); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (data !== {8'h80, grey[i/2]}) begin
                errors++;
                $display("FAIL grey_px%0d got=%h want=80%h", i, data, grey[i/2]);
            end
            step(1);
        end
    endtask

    task automatic test_checker();
        bit ok;
        mode = 2'd2;
        wait_fs(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL chk_fs_timeout got=%b want=1", ok); end
        checks++; if (data !== 16'h8010) begin errors++; $display("FAIL chk_x0y0 got=%h want=8010", data); end
        step(4);
        checks++; if (data !== 16'h80EB) begin errors++; $display("FAIL chk_x4y0 got=%h want=80eb", data); end
        step(4);
        checks++; if (data !== 16'h8010) begin errors++; $display("FAIL chk_x8y0 got=%h want=8010", data); end
        step(4);
        checks++; if (data !== 16'h80EB) begin errors++; $display("FAIL chk_x12y0 got=%h want=80eb", data); end
        step(84);
        checks++; if (data !== 16'h80EB) begin errors++; $display("FAIL chk_x0y4 got=%h want=80eb", data); end
        step(4);
        checks++; if (data !== 16'h8010) begin errors++; $display("FAIL chk_x4y4 got=%h want=8010", data); end
    endtask

    task automatic test_config_drop();
        bit ok;
        wait_fs(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drop_fs_timeout got=%b want=1", ok); end
        checks++; if (fcnt !== 8'd6) begin errors++; $display("FAIL drop_fcnt_before got=%0d want=6", fcnt); end
        step(5);
        config_ok = 1'b0;
        step(1);
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL drop_de_c0 got=%b want=1", de); end
        step(1);
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL drop_de_c1 got=%b want=1", de); end
        step(1);
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL drop_de_c2 got=%b want=0", de); end
        checks++; if (data !== 16'h8010) begin errors++; $display("FAIL drop_data got=%h want=8010", data); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL drop_hsync got=%b want=1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL drop_vsync got=%b want=1", vsync); end
        checks++; if (fcnt !== 8'd0) begin errors++; $display("FAIL drop_fcnt got=%0d want=0", fcnt); end
        step(4);
        checks++; if (de !== 1'b0 || fs !== 1'b0) begin
            errors++; $display("FAIL drop_idle de=%b fs=%b want=0,0", de, fs);
        end
    endtask

    task automatic test_scroll();
        logic [15:0] masks [5];
        logic [15:0] m;
        bit ok;
        masks = '{16'h003F, 16'h03F0, 16'h3F00, 16'hF003, 16'h003F};
        mode = 2'd3;
        config_ok = 1'b1;
        step(2);
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL restart_de_c1 got=%b want=0", de); end
        step(1);
        checks++; if (fs !== 1'b1 || de !== 1'b1) begin
            errors++; $display("FAIL restart_fs fs=%b de=%b want=1,1", fs, de);
        end
        checks++; if (fcnt !== 8'd0) begin errors++; $display("FAIL restart_fcnt got=%0d want=0", fcnt); end
        for (int f = 0; f < 5; f++) begin
            if (f > 0) begin
                wait_fs(ok);
                checks++; if (ok !== 1'b1) begin errors++; $display("FAIL scroll_fs%0d_timeout", f); end
            end
            m = masks[f];
            for (int x = 0; x < 16; x++) begin
                checks++;
                if (data !== (m[x] ? 16'h80EB : 16'h8010)) begin
                    errors++;
                    $display("FAIL scroll_f%0d_x%0d got=%h want=%h", f, x, data,
                             m[x] ? 16'h80EB : 16'h8010);
                end
                step(1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup_timing();
        test_bars();
        test_mode_change();
        test_checker();
        test_config_drop();
        test_scroll();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
